// File: rtl/spi_peek_master_pkg.sv
// Shared definitions for the SPI peek master: FSM states, default geometry
// and the bit layout of the 64-bit request/response frames.
package spi_peek_master_pkg;

  localparam int unsigned DEF_FRAME_BITS = 64;
  localparam int unsigned DEF_CLK_DIV    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Outbound request frame fields
  localparam int unsigned REQ_REQ_BIT   = 63;
  localparam int unsigned REQ_RH_WL_BIT = 62;
  localparam int unsigned REQ_LED_MSB   = 55;
  localparam int unsigned REQ_LED_LSB   = 48;
  localparam int unsigned REQ_ADDR_MSB  = 23;
  localparam int unsigned REQ_ADDR_LSB  = 0;

  // Inbound response frame fields
  localparam int unsigned RSP_ACK_BIT       = 63;
  localparam int unsigned RSP_DATA_R_EN_BIT = 62;
  localparam int unsigned RSP_DATA_MSB      = 47;
  localparam int unsigned RSP_DATA_LSB      = 32;

  typedef struct packed {
    logic        req;
    logic        rh_wl;
    logic [5:0]  rsvd_hi;
    logic [7:0]  led;
    logic [23:0] rsvd_lo;
    logic [23:0] addr;
  } req_frame_t;

  typedef struct packed {
    logic        ack;
    logic        data_r_en;
    logic [13:0] rsvd_hi;
    logic [15:0] data;
    logic [31:0] rsvd_lo;
  } rsp_frame_t;

endpackage

// File: rtl/spi_peek_master_sync2.sv
// Two-flop synchroniser for the asynchronous MISO input, clears to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic reset_l,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_peek_master.sv
// SPI mode-0 master: shifts one FRAME_BITS-wide frame MSB-first per start,
// framed by spi_sel_n with setup, hold and inter-frame gap phases.
module spi_peek_master
  import spi_peek_master_pkg::*;
#(
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  spi_sel_n,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int unsigned HW = $clog2(CLK_DIV + 1);
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);
  localparam logic [HW-1:0] HRELOAD = HW'(CLK_DIV - 1);

  state_e                state, state_nxt;
  logic [HW-1:0]         hcnt, hcnt_nxt;
  logic [BW-1:0]         bcnt, bcnt_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt, rx_nxt;
  logic                  done_nxt, busy_nxt, sel_n_nxt, sclk_nxt, mosi_nxt;
  logic                  miso_s;
  logic                  phase_end;

  sync2 u_sync2 (
    .clk     (clk),
    .reset_l (reset_l),
    .d       (spi_miso),
    .q       (miso_s)
  );

  assign phase_end = (hcnt == '0);

  // Next-state, datapath and pin values; pins are registered from these
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    bcnt_nxt  = bcnt;
    shreg_nxt = shreg;
    rx_nxt    = rx_data;
    done_nxt  = 1'b0;

    if (!phase_end) hcnt_nxt = hcnt - HW'(1);

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SETUP;
          hcnt_nxt  = HRELOAD;
          bcnt_nxt  = '0;
          shreg_nxt = tx_data;
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          state_nxt = ST_LOW;
          hcnt_nxt  = HRELOAD;
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          state_nxt = ST_HIGH;
          hcnt_nxt  = HRELOAD;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          shreg_nxt = {shreg[FRAME_BITS-2:0], miso_s};
          bcnt_nxt  = bcnt + BW'(1);
          hcnt_nxt  = HRELOAD;
          state_nxt = (32'(bcnt_nxt) < FRAME_BITS) ? ST_LOW : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (phase_end) begin
          state_nxt = ST_GAP;
          hcnt_nxt  = HRELOAD;
          rx_nxt    = shreg;
          done_nxt  = 1'b1;
        end
      end
      ST_GAP: begin
        if (phase_end) begin
          state_nxt = ST_IDLE;
          hcnt_nxt  = HRELOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt  = (state_nxt != ST_IDLE);
    sel_n_nxt = !(state_nxt inside {ST_SETUP, ST_LOW, ST_HIGH, ST_HOLD});
    sclk_nxt  = (state_nxt == ST_HIGH);
    // MOSI idles low outside the selected window
    mosi_nxt  = !sel_n_nxt && shreg_nxt[FRAME_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state     <= ST_IDLE;
      hcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      spi_sel_n <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      bcnt      <= bcnt_nxt;
      shreg     <= shreg_nxt;
      rx_data   <= rx_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      spi_sel_n <= sel_n_nxt;
      spi_sclk  <= sclk_nxt;
      spi_mosi  <= mosi_nxt;
    end
  end

endmodule

// File: tb/tb_spi_peek_master.sv
// Bench for spi_peek_master: a default-geometry instance with a mode-0 slave
// model and loopback option, plus a CLK_DIV=3 / 16-bit instance.
module tb_spi_peek_master;

  localparam int unsigned F0 = 64;
  localparam int unsigned D0 = 4;
  localparam int unsigned F1 = 16;
  localparam int unsigned D1 = 3;
  localparam int unsigned SEL_LOW0 = D0 * (2 * F0 + 2);
  localparam int unsigned SEL_LOW1 = D1 * (2 * F1 + 2);
  localparam int unsigned PERIOD0  = SEL_LOW0 + D0 + 1;

  logic clk = 1'b0;
  logic reset_l = 1'b0;

  logic          start0 = 1'b0;
  logic [F0-1:0] tx0 = '0;
  logic          busy0, done0, sel0, sclk0, mosi0, miso0;
  logic [F0-1:0] rx0;

  logic          start1 = 1'b0;
  logic [F1-1:0] tx1 = '0;
  logic          busy1, done1, sel1, sclk1, mosi1, miso1;
  logic [F1-1:0] rx1;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 clk = ~clk;

  spi_peek_master #(.FRAME_BITS(F0), .CLK_DIV(D0)) u_dut0 (
    .clk(clk), .reset_l(reset_l), .start(start0), .tx_data(tx0),
    .busy(busy0), .done(done0), .rx_data(rx0),
    .spi_sel_n(sel0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso0)
  );

  spi_peek_master #(.FRAME_BITS(F1), .CLK_DIV(D1)) u_dut1 (
    .clk(clk), .reset_l(reset_l), .start(start1), .tx_data(tx1),
    .busy(busy1), .done(done1), .rx_data(rx1),
    .spi_sel_n(sel1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  // Pin monitors: select-low/high run lengths, done timestamps, SCLK period
  int unsigned cyc = 0;
  int unsigned done_cnt0 = 0, low_run0 = 0, last_low0 = 0, high_run0 = 0, last_high0 = 0;
  int unsigned done_t0[$];
  int unsigned done_cnt1 = 0, low_run1 = 0, last_low1 = 0;
  int unsigned last_rise1 = 0, sclk_per1 = 0;
  logic        sclk1_q = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done0 === 1'b1) begin
      done_cnt0 <= done_cnt0 + 1;
      done_t0.push_back(cyc);
    end
    if (sel0 === 1'b0) begin
      low_run0 <= low_run0 + 1;
      if (high_run0 != 0) begin last_high0 <= high_run0; high_run0 <= 0; end
    end else begin
      high_run0 <= high_run0 + 1;
      if (low_run0 != 0) begin last_low0 <= low_run0; low_run0 <= 0; end
    end
    if (done1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
    if (sel1 === 1'b0) low_run1 <= low_run1 + 1;
    else if (low_run1 != 0) begin last_low1 <= low_run1; low_run1 <= 0; end
    if (sclk1 === 1'b1 && sclk1_q === 1'b0) begin
      if (last_rise1 != 0) sclk_per1 <= cyc - last_rise1;
      last_rise1 <= cyc;
    end
    sclk1_q <= sclk1;
  end

  // Mode-0 slave models: present next bit after each SCLK fall, capture MOSI on rise
  logic [F0-1:0] slave_word0 = '0, mosi_cap0 = '0;
  logic          slave_bit0 = 1'b0, sclk0_p = 1'b0, sel0_p = 1'b1, mosi0_d = 1'b0;
  logic          loop_mode = 1'b0;
  int            idx0 = 0, rise_cnt0 = 0;

  always @(negedge clk) begin
    if (sel0) begin
      idx0       <= 0;
      slave_bit0 <= slave_word0[F0-1];
    end else begin
      if (sel0_p) rise_cnt0 <= 0;
      if (sclk0 && !sclk0_p) begin
        mosi_cap0 <= {mosi_cap0[F0-2:0], mosi0};
        rise_cnt0 <= rise_cnt0 + 1;
      end
      if (!sclk0 && sclk0_p) begin
        idx0       <= idx0 + 1;
        slave_bit0 <= (idx0 + 1 < int'(F0)) ? slave_word0[F0-2-idx0] : 1'b0;
      end
    end
    sclk0_p <= sclk0;
    sel0_p  <= sel0;
  end

  always @(posedge clk) mosi0_d <= mosi0;
  assign miso0 = loop_mode ? mosi0_d : slave_bit0;

  logic [F1-1:0] slave_word1 = 16'hAAAA, mosi_cap1 = '0;
  logic          slave_bit1 = 1'b0, sclk1_p = 1'b0;
  int            idx1 = 0;

  always @(negedge clk) begin
    if (sel1) begin
      idx1       <= 0;
      slave_bit1 <= slave_word1[F1-1];
    end else begin
      if (sclk1 && !sclk1_p) mosi_cap1 <= {mosi_cap1[F1-2:0], mosi1};
      if (!sclk1 && sclk1_p) begin
        idx1       <= idx1 + 1;
        slave_bit1 <= (idx1 + 1 < int'(F1)) ? slave_word1[F1-2-idx1] : 1'b0;
      end
    end
    sclk1_p <= sclk1;
  end
  assign miso1 = slave_bit1;

  task automatic run_frame0(input logic [F0-1:0] tx, input logic [F0-1:0] word,
                            input logic loop, input string name);
    logic [F0-1:0] exp_rx;
    int unsigned   d0;
    bit            got;
    exp_rx      = loop ? tx : word;
    tx0         = tx;
    slave_word0 = word;
    loop_mode   = loop;
    @(negedge clk);
    d0     = done_cnt0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done0 === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout: no done within 2000 cycles", name);
    end else begin
      vectors++;
      if (rx0 !== exp_rx) begin
        errors++;
        $display("FAIL %s rx_data: got %h expected %h", name, rx0, exp_rx);
      end
      repeat (D0 + 3) @(negedge clk);
      vectors++;
      if (last_low0 !== SEL_LOW0) begin
        errors++;
        $display("FAIL %s sel_low_cycles: got %0d expected %0d", name, last_low0, SEL_LOW0);
      end
      vectors++;
      if (mosi_cap0 !== tx || rise_cnt0 != int'(F0)) begin
        errors++;
        $display("FAIL %s mosi_bits: got %h (%0d rises) expected %h (%0d rises)",
                 name, mosi_cap0, rise_cnt0, tx, F0);
      end
      vectors++;
      if (done_cnt0 - d0 != 1 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL %s done_once: got %0d pulses busy=%b expected 1 pulse busy=0",
                 name, done_cnt0 - d0, busy0);
      end
    end
    loop_mode = 1'b0;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    start0  = 1'b1;
    start1  = 1'b1;
    tx0     = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy0, done0, sel0, sclk0, mosi0} !== 5'b00100 || rx0 !== '0) begin
      errors++;
      $display("FAIL reset_outputs0: got busy=%b done=%b sel_n=%b sclk=%b mosi=%b rx=%h expected 0 0 1 0 0 0",
               busy0, done0, sel0, sclk0, mosi0, rx0);
    end
    vectors++;
    if ({busy1, done1, sel1, sclk1, mosi1} !== 5'b00100 || rx1 !== '0) begin
      errors++;
      $display("FAIL reset_outputs1: got busy=%b done=%b sel_n=%b sclk=%b mosi=%b rx=%h expected 0 0 1 0 0 0",
               busy1, done1, sel1, sclk1, mosi1, rx1);
    end
    reset_l = 1'b1;
    start0  = 1'b0;
    start1  = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy0 !== 1'b0 || sel0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_start_ignored: got busy=%b sel_n=%b expected busy=0 sel_n=1", busy0, sel0);
    end
  endtask

  task automatic test_single_frame();
    run_frame0(64'hA5A5_0000_DEAD_BEEF, 64'h8000_1234_0000_0000, 1'b0, "single_frame");
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 4; k++)
      run_frame0({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, $sformatf("random_frame%0d", k));
  endtask

  task automatic test_busy_collision();
    logic [F0-1:0] word;
    int unsigned   d0;
    word        = {$urandom, $urandom};
    slave_word0 = word;
    tx0         = {$urandom, $urandom};
    @(negedge clk);
    d0 = done_cnt0;
    for (int c = 0; c < 1300; c++) begin
      start0 = (c == 0 || c == 10 || c == 200);
      @(negedge clk);
    end
    start0 = 1'b0;
    vectors++;
    if (done_cnt0 - d0 != 1) begin
      errors++;
      $display("FAIL busy_collision_frames: got %0d done pulses expected 1", done_cnt0 - d0);
    end
    vectors++;
    if (rx0 !== word || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL busy_collision_rx: got rx=%h busy=%b expected rx=%h busy=0", rx0, busy0, word);
    end
  endtask

  task automatic test_back_to_back();
    logic [F0-1:0] word;
    int unsigned   d0, n0, gap_a, gap_b;
    word        = {$urandom, $urandom};
    slave_word0 = word;
    tx0         = {$urandom, $urandom};
    @(negedge clk);
    d0 = done_cnt0;
    n0 = done_t0.size();
    start0 = 1'b1;
    for (int i = 0; i < 3 * int'(PERIOD0) + 100; i++) begin
      if (done_cnt0 - d0 >= 3) break;
      @(negedge clk);
    end
    start0 = 1'b0;
    vectors++;
    if (done_cnt0 - d0 != 3) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d done pulses expected 3", done_cnt0 - d0);
    end else begin
      gap_a = done_t0[n0+1] - done_t0[n0];
      gap_b = done_t0[n0+2] - done_t0[n0+1];
      vectors++;
      if (gap_a != PERIOD0 || gap_b != PERIOD0) begin
        errors++;
        $display("FAIL b2b_done_spacing: got %0d,%0d expected %0d,%0d", gap_a, gap_b, PERIOD0, PERIOD0);
      end
      vectors++;
      if (last_high0 != D0 + 1) begin
        errors++;
        $display("FAIL b2b_sel_high: got %0d expected %0d", last_high0, D0 + 1);
      end
      vectors++;
      if (rx0 !== word) begin
        errors++;
        $display("FAIL b2b_rx: got %h expected %h", rx0, word);
      end
    end
    repeat (PERIOD0 + 50) @(negedge clk);
    vectors++;
    if (done_cnt0 - d0 != 3 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: got %0d pulses busy=%b expected 3 pulses busy=0", done_cnt0 - d0, busy0);
    end
  endtask

  task automatic test_reset_midframe();
    int unsigned d0;
    bit          hit;
    tx0         = {$urandom, $urandom};
    slave_word0 = {$urandom, $urandom};
    @(negedge clk);
    d0     = done_cnt0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rise_cnt0 == 30) begin hit = 1'b1; break; end
    end
    vectors++;
    if (!hit) begin
      errors++;
      $display("FAIL midreset_timeout: 30th SCLK rise not seen, rises=%0d", rise_cnt0);
    end
    reset_l = 1'b0;
    @(negedge clk);
    vectors++;
    if (sel0 !== 1'b1 || busy0 !== 1'b0 || rx0 !== '0 || sclk0 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: got sel_n=%b busy=%b sclk=%b rx=%h expected 1 0 0 0",
               sel0, busy0, sclk0, rx0);
    end
    @(negedge clk);
    reset_l = 1'b1;
    repeat (700) @(negedge clk);
    vectors++;
    if (done_cnt0 != d0 || rx0 !== '0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d pulses rx=%h expected 0 pulses rx=0", done_cnt0 - d0, rx0);
    end
    run_frame0({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, "after_midreset");
  endtask

  task automatic test_div3();
    int unsigned d1;
    bit          got;
    tx1 = F1'($urandom);
    @(negedge clk);
    d1     = done_cnt1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (done1 === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL div3_timeout: no done within 500 cycles");
    end else begin
      vectors++;
      if (rx1 !== 16'hAAAA) begin
        errors++;
        $display("FAIL div3_rx: got %h expected aaaa", rx1);
      end
      repeat (D1 + 3) @(negedge clk);
      vectors++;
      if (last_low1 != SEL_LOW1) begin
        errors++;
        $display("FAIL div3_sel_low: got %0d expected %0d", last_low1, SEL_LOW1);
      end
      vectors++;
      if (sclk_per1 != 2 * D1) begin
        errors++;
        $display("FAIL div3_sclk_period: got %0d expected %0d", sclk_per1, 2 * D1);
      end
      vectors++;
      if (mosi_cap1 !== tx1 || done_cnt1 - d1 != 1 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL div3_mosi_done: got mosi=%h pulses=%0d busy=%b expected mosi=%h pulses=1 busy=0",
                 mosi_cap1, done_cnt1 - d1, busy1, tx1);
      end
    end
  endtask

  task automatic test_loopback();
    run_frame0(64'h0123_4567_89AB_CDEF, {$urandom, $urandom}, 1'b1, "loopback");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_busy_collision();
    test_back_to_back();
    test_reset_midframe();
    test_div3();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
